// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  localparam logic IDLE_LEVEL = 1'b1;

  // Holds 0..DATA_BITS-1 for any legal DATA_BITS (5..8).
  localparam int unsigned CNT_W = 3;

  // Narrower data is zero-extended, which leaves the XOR reduction unchanged.
  function automatic logic calc_parity(input int unsigned mode, input logic [7:0] data);
    return (mode == PARITY_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one-entry holding register feeding a baud-tick driven framer.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy
);

  state_e               r_state;
  state_e               w_state_next;
  logic                 r_tx_ready;
  logic [DATA_BITS-1:0] r_hold_data;
  logic [DATA_BITS-1:0] r_shift;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic                 r_stop_cnt;
  logic                 r_parity;
  logic                 r_txd;

  logic [DATA_BITS-1:0] w_shift_next;
  logic [CNT_W-1:0]     w_bit_cnt_next;
  logic                 w_stop_cnt_next;
  logic                 w_parity_next;
  logic                 w_txd_next;
  logic                 w_hold_full;
  logic                 w_last_data;
  logic                 w_last_stop;
  logic                 w_load;

  assign w_hold_full = ~r_tx_ready;
  assign w_last_data = (r_bit_cnt == CNT_W'(DATA_BITS - 1));
  assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));

  // A byte leaves the holding register only at a frame boundary tick.
  assign w_load = baud_tick & w_hold_full &
                  ((r_state == StIdle) | ((r_state == StStop) & w_last_stop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_ready  <= 1'b1;
      r_hold_data <= '0;
    end else if (w_load) begin
      r_tx_ready  <= 1'b1;
    end else if (tx_valid && r_tx_ready) begin
      r_tx_ready  <= 1'b0;
      r_hold_data <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (baud_tick) begin
      unique case (r_state)
        StIdle:   if (w_hold_full) w_state_next = StStart;
        StStart:  w_state_next = StData;
        StData: begin
          if (w_last_data) w_state_next = (PARITY != PARITY_NONE) ? StParity : StStop;
        end
        StParity: w_state_next = StStop;
        StStop: begin
          if (w_last_stop) w_state_next = w_hold_full ? StStart : StIdle;
        end
        default:  w_state_next = StIdle;
      endcase
    end
  end

  always_comb begin
    w_txd_next      = r_txd;
    w_shift_next    = r_shift;
    w_bit_cnt_next  = r_bit_cnt;
    w_stop_cnt_next = r_stop_cnt;
    w_parity_next   = r_parity;
    if (w_load) begin
      w_shift_next  = r_hold_data;
      w_parity_next = calc_parity(PARITY, 8'(r_hold_data));
      w_txd_next    = 1'b0;
    end else if (baud_tick) begin
      unique case (r_state)
        StStart: begin
          w_txd_next     = r_shift[0];
          w_shift_next   = r_shift >> 1;
          w_bit_cnt_next = '0;
        end
        StData: begin
          if (!w_last_data) begin
            w_txd_next     = r_shift[0];
            w_shift_next   = r_shift >> 1;
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end else begin
            w_txd_next      = (PARITY != PARITY_NONE) ? r_parity : IDLE_LEVEL;
            w_stop_cnt_next = 1'b0;
          end
        end
        StParity: begin
          w_txd_next      = IDLE_LEVEL;
          w_stop_cnt_next = 1'b0;
        end
        StStop: begin
          w_txd_next = IDLE_LEVEL;
          if (!w_last_stop) w_stop_cnt_next = r_stop_cnt + 1'b1;
        end
        default: w_txd_next = IDLE_LEVEL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txd      <= IDLE_LEVEL;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_parity   <= 1'b0;
    end else begin
      r_txd      <= w_txd_next;
      r_shift    <= w_shift_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_stop_cnt <= w_stop_cnt_next;
      r_parity   <= w_parity_next;
    end
  end

  assign txd      = r_txd;
  assign tx_ready = r_tx_ready;
  assign tx_busy  = (r_state != StIdle) | w_hold_full;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench: four frame formats run side by side, each decoding its own serial line.
module tb_uart_tx_serializer;

  localparam int NCFG = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk    = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input string why);
    n_chk++;
    $display("FAIL %s: %s", name, why);
  endtask

  // cfg0 8N1, cfg1 8E2, cfg2 8O2, cfg3 5E1
  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int unsigned DB   = (g == 3) ? 5 : 8;
    localparam int unsigned PAR  = (g == 0) ? 0 : ((g == 2) ? 1 : 2);
    localparam int unsigned SB   = (g == 0 || g == 3) ? 1 : 2;
    localparam int unsigned FLEN = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;

    logic          rst_n;
    logic          baud_tick;
    logic [DB-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          txd;
    logic          tx_busy;

    uart_tx_serializer #(
      .DATA_BITS(DB),
      .PARITY   (PAR),
      .STOP_BITS(SB)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .baud_tick(baud_tick),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .txd      (txd),
      .tx_busy  (tx_busy)
    );

    // Line levels per bit interval, bit 0 first; unused upper bits left high.
    function automatic logic [15:0] model_frame(input logic [7:0] b);
      logic [15:0] f = '1;
      int ones = 0;
      f[0] = 1'b0;
      for (int i = 0; i < int'(DB); i++) begin
        f[1 + i] = b[i];
        ones += int'(b[i]);
      end
      // even: parity bit makes the total count of ones even; odd: makes it odd
      if (PAR != 0) f[1 + DB] = (((ones + ((PAR == 1) ? 1 : 0)) % 2) != 0);
      return f;
    endfunction

    logic [15:0] exp_q[$];
    int          tick_per = 8;
    int          mon_n    = 0;
    int          gap      = 0;
    int          last_gap = 0;
    logic [15:0] obs;

    always @(posedge clk)
      if (rst_n === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1)
        exp_q.push_back(model_frame(8'(tx_data)));

    initial begin
      int cnt = 0;
      baud_tick = 1'b0;
      forever begin
        @(negedge clk);
        cnt++;
        if (cnt >= tick_per) cnt = 0;
        baud_tick = (cnt == 0);
      end
    end

    // Line decoder: one sample per bit interval, taken just after each tick edge.
    initial begin
      logic        tick_s;
      logic [15:0] e;
      forever begin
        @(posedge clk);
        tick_s = baud_tick;
        #1;
        if (rst_n !== 1'b1) begin
          mon_n = 0;
          gap   = 0;
        end else if (tick_s) begin
          if (mon_n == 0 && txd === 1'b1) begin
            gap++;
          end else begin
            if (mon_n == 0) begin
              obs      = '1;
              last_gap = gap;
              gap      = 0;
            end
            obs[mon_n] = txd;
            mon_n++;
            if (mon_n == int'(FLEN)) begin
              mon_n = 0;
              if (exp_q.size() == 0) begin
                fail_now($sformatf("cfg%0d frame", g), $sformatf("unexpected frame 0x%0h", obs));
              end else begin
                e = exp_q.pop_front();
                chk($sformatf("cfg%0d frame", g), 32'(obs), 32'(e));
              end
            end
          end
        end
      end
    end

    task automatic send(input logic [7:0] b, input bit hold_valid);
      int   t   = 0;
      logic acc = 1'b0;
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = DB'(b);
      while (!acc && t < 3000) begin
        @(posedge clk);
        acc = tx_ready;
        t++;
      end
      if (acc !== 1'b1) begin
        fail_now($sformatf("cfg%0d accept", g), "timeout waiting for tx_ready");
      end else begin
        #1;
        chk($sformatf("cfg%0d ready_after_accept", g), 32'(tx_ready), 32'd0);
      end
      if (!hold_valid) begin
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = DB'($urandom);
      end
    endtask

    task automatic wait_idle(input string tag);
      int t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (tx_busy !== 1'b0 && t < 5000);
      if (tx_busy !== 1'b0) begin
        fail_now($sformatf("cfg%0d %s", g, tag), "timeout waiting for tx_busy low");
      end else begin
        chk($sformatf("cfg%0d %s pending", g, tag), 32'(exp_q.size()), 32'd0);
        chk($sformatf("cfg%0d %s txd_idle", g, tag), 32'(txd), 32'd1);
      end
    endtask

    task automatic wait_txd_low(input string tag);
      int t = 0;
      while (txd !== 1'b0 && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (txd !== 1'b0) fail_now($sformatf("cfg%0d %s", g, tag), "start bit never seen");
    endtask

    initial begin
      int   t;
      int   c;
      bit   hv;
      logic tick_s;
      rst_n    = 1'b1;
      tx_valid = 1'b0;
      tx_data  = '0;
      #2 rst_n = 1'b0;
      #10;
      chk($sformatf("cfg%0d reset txd", g), 32'(txd), 32'd1);
      chk($sformatf("cfg%0d reset ready", g), 32'(tx_ready), 32'd1);
      chk($sformatf("cfg%0d reset busy", g), 32'(tx_busy), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // basic frame; holding register must be free again once the byte is loaded
      send(8'hA5, 1'b0);
      wait_txd_low("basic");
      chk($sformatf("cfg%0d ready_after_load", g), 32'(tx_ready), 32'd1);
      wait_idle("basic");

      // back-to-back: second start bit directly follows the last stop bit
      send(8'h00, 1'b0);
      send(8'hFF, 1'b0);
      wait_idle("b2b");
      chk($sformatf("cfg%0d b2b gap", g), 32'(last_gap), 32'd0);

      // back-pressure with tx_valid held high across three bytes
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      send(8'h33, 1'b0);
      wait_idle("backpressure");

      send(8'h07, 1'b0);
      wait_idle("parity");

      // accept coinciding with an IDLE tick must wait for the following tick
      t = 0;
      do begin
        @(posedge clk);
        t++;
      end while (baud_tick !== 1'b1 && t < 100);
      repeat (tick_per) @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = DB'(8'h3C);
      @(posedge clk);
      #1;
      chk($sformatf("cfg%0d corner no_start", g), 32'(txd), 32'd1);
      chk($sformatf("cfg%0d corner accepted", g), 32'(tx_ready), 32'd0);
      @(negedge clk);
      tx_valid = 1'b0;
      t = 0;
      do begin
        @(posedge clk);
        tick_s = baud_tick;
        t++;
      end while (tick_s !== 1'b1 && t < 100);
      #1;
      chk($sformatf("cfg%0d corner start_next_tick", g), 32'(txd), 32'd0);
      wait_idle("corner");

      // reset during data bit 3 with a second byte waiting in the holding register
      send(8'hC3, 1'b0);
      send(8'h99, 1'b0);
      t = 0;
      while (mon_n != 5 && t < 1000) begin
        @(negedge clk);
        t++;
      end
      if (mon_n != 5) fail_now($sformatf("cfg%0d midreset", g), "data bit 3 never reached");
      #2 rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk($sformatf("cfg%0d midreset txd", g), 32'(txd), 32'd1);
      chk($sformatf("cfg%0d midreset ready", g), 32'(tx_ready), 32'd1);
      chk($sformatf("cfg%0d midreset busy", g), 32'(tx_busy), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3 * FLEN * tick_per) @(negedge clk);
      chk($sformatf("cfg%0d postreset quiet", g), 32'(mon_n), 32'd0);
      chk($sformatf("cfg%0d postreset busy", g), 32'(tx_busy), 32'd0);
      send(8'h5A, 1'b0);
      wait_idle("postreset");

      // baud_tick tied high: one bit per clk
      tick_per = 1;
      send(8'hA5, 1'b0);
      wait_txd_low("tied");
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (tx_busy !== 1'b0 && c < 100);
      chk($sformatf("cfg%0d tied frame_clks", g), 32'(c), 32'(FLEN));
      wait_idle("tied");

      // randomized traffic against the frame model
      repeat (25) begin
        tick_per = $urandom_range(1, 6);
        hv = 1'($urandom_range(0, 1));
        send(8'($urandom), hv);
        if (!hv) repeat ($urandom_range(0, 2 * FLEN * tick_per)) @(negedge clk);
      end
      @(negedge clk);
      tx_valid = 1'b0;
      wait_idle("random");
      done_cnt++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    wait (done_cnt == NCFG);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
